// File: rtl/ysyx_25040129_wbq.sv
// ysyx_25040129_wbq: in-order write-back queue with GPR forwarding, EBREAK halt and retire counter
`ifndef ysyx_25040129_REGS_DIG
`define ysyx_25040129_REGS_DIG 5
`endif
`ifndef ysyx_25040129_CSR_DIG
`define ysyx_25040129_CSR_DIG 12
`endif

module ysyx_25040129_wbq #(
    parameter int DEPTH  = 4,
    parameter int XLEN   = 32,
    parameter int REG_AW = `ysyx_25040129_REGS_DIG,
    parameter int CSR_AW = `ysyx_25040129_CSR_DIG
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [REG_AW-1:0]          in_rd,
    input  logic [XLEN-1:0]            in_result,
    input  logic                       in_reg_write,
    input  logic                       in_csr_write,
    input  logic [CSR_AW-1:0]          in_csr_addr,
    input  logic                       in_ebreak,
    input  logic                       wb_ready,
    output logic                       rf_we,
    output logic [REG_AW-1:0]          rf_rd,
    output logic [XLEN-1:0]            rf_wdata,
    output logic                       csr_we,
    output logic [CSR_AW-1:0]          csr_addr,
    output logic [XLEN-1:0]            csr_wdata,
    input  logic [REG_AW-1:0]          fwd_rs,
    output logic                       fwd_hit,
    output logic [XLEN-1:0]            fwd_data,
    input  logic                       flush,
    output logic                       halt,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [31:0]                retire_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [REG_AW-1:0] e_rd  [DEPTH];
    logic [XLEN-1:0]   e_res [DEPTH];
    logic [CSR_AW-1:0] e_ca  [DEPTH];
    logic [DEPTH-1:0]  e_rw, e_cw, e_eb;
    logic [PW:0]       wptr, rptr;
    logic [PW-1:0]     h, k;
    logic              empty, full, push, pop;

    assign h        = rptr[PW-1:0];
    assign empty    = wptr == rptr;
    assign full     = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign in_ready = !full && !halt && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = !empty && wb_ready && !halt && !flush;

    assign rf_we     = pop && e_rw[h] && (e_rd[h] != '0);
    assign csr_we    = pop && e_cw[h];
    assign rf_rd     = empty ? '0 : e_rd[h];
    assign rf_wdata  = empty ? '0 : e_res[h];
    assign csr_addr  = empty ? '0 : e_ca[h];
    assign csr_wdata = empty ? '0 : e_res[h];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            halt       <= 1'b0;
            retire_cnt <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr       <= wptr + (PW+1)'(push);
            rptr       <= rptr + (PW+1)'(pop);
            count      <= count + CW'(push) - CW'(pop);
            halt       <= halt | (pop && e_eb[h]);
            retire_cnt <= retire_cnt + 32'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            e_rd[wptr[PW-1:0]]  <= in_rd;
            e_res[wptr[PW-1:0]] <= in_result;
            e_ca[wptr[PW-1:0]]  <= in_csr_addr;
            e_rw[wptr[PW-1:0]]  <= in_reg_write;
            e_cw[wptr[PW-1:0]]  <= in_csr_write;
            e_eb[wptr[PW-1:0]]  <= in_ebreak;
        end
    end

    // scan oldest to youngest so the last match wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        k        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            k = h + PW'(i);
            if (CW'(i) < count && e_rw[k] && e_rd[k] == fwd_rs && fwd_rs != '0) begin
                fwd_hit  = 1'b1;
                fwd_data = e_res[k];
            end
        end
    end
endmodule

// File: tb/tb_ysyx_25040129_wbq.sv
// tb_ysyx_25040129_wbq: table, directed and random checks of the write-back queue against a queue model
module tb_ysyx_25040129_wbq;
    typedef struct {
        logic v; logic [4:0] rd; logic [31:0] res; logic rw, cw;
        logic [11:0] ca; logic eb, wr; logic [4:0] fr; logic fl;
    } stim_t;
    typedef struct {
        logic [4:0] rd; logic [31:0] res; logic rw, cw; logic [11:0] ca; logic eb;
    } ent_t;
    typedef struct {
        stim_t s; logic rdy, we; logic [4:0] rd; logic [31:0] wd;
        logic [2:0] cnt; logic hit; logic [31:0] fd; logic [31:0] rc;
    } vec_t;

    logic clock = 0, reset_n = 1;
    logic in_valid = 0, in_reg_write = 0, in_csr_write = 0, in_ebreak = 0, wb_ready = 0, flush = 0;
    logic [4:0] in_rd = 0, fwd_rs = 0;
    logic [31:0] in_result = 0;
    logic [11:0] in_csr_addr = 0;
    logic in_ready, rf_we, csr_we, fwd_hit, halt;
    logic [4:0] rf_rd;
    logic [31:0] rf_wdata, csr_wdata, fwd_data, retire_cnt;
    logic [11:0] csr_addr;
    logic [2:0] count;

    ysyx_25040129_wbq #(.DEPTH(4), .XLEN(32), .REG_AW(5), .CSR_AW(12)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_result(in_result), .in_reg_write(in_reg_write),
        .in_csr_write(in_csr_write), .in_csr_addr(in_csr_addr), .in_ebreak(in_ebreak),
        .wb_ready(wb_ready), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .fwd_rs(fwd_rs),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .flush(flush), .halt(halt),
        .count(count), .retire_cnt(retire_cnt)
    );

    always #5 clock = ~clock;

    int n_vec = 0, n_bad = 0;
    ent_t q[$];
    logic halt_m = 0;
    logic [31:0] rc_m = 0;
    logic m_push, m_pop;
    stim_t cur;
    vec_t tbl[6];

    function automatic stim_t mk(input int v, rd, res, rw, cw, ca, eb, wr, fr, fl);
        stim_t s;
        s.v = v[0]; s.rd = rd[4:0]; s.res = res; s.rw = rw[0]; s.cw = cw[0];
        s.ca = ca[11:0]; s.eb = eb[0]; s.wr = wr[0]; s.fr = fr[4:0]; s.fl = fl[0];
        return s;
    endfunction

    function automatic vec_t mkv(input stim_t s, input int rdy, we, rd, wd, cnt, hit, fd, rc);
        vec_t t;
        t.s = s; t.rdy = rdy[0]; t.we = we[0]; t.rd = rd[4:0]; t.wd = wd;
        t.cnt = cnt[2:0]; t.hit = hit[0]; t.fd = fd; t.rc = rc;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic check_all();
        ent_t hd;
        logic hit;
        logic [31:0] fd;
        logic rdy;
        hd = '{default: '0};
        if (q.size() != 0) hd = q[0];
        rdy = q.size() != 4 && !halt_m && !cur.fl;
        m_push = cur.v && rdy;
        m_pop = q.size() != 0 && cur.wr && !halt_m && !cur.fl;
        hit = 0; fd = 0;
        if (cur.fr != 0)
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].rw && q[i].rd == cur.fr) begin hit = 1; fd = q[i].res; break; end
        chk("in_ready", in_ready, rdy);
        chk("rf_we", rf_we, m_pop && hd.rw && hd.rd != 0);
        chk("rf_rd", rf_rd, hd.rd);
        chk("rf_wdata", rf_wdata, hd.res);
        chk("csr_we", csr_we, m_pop && hd.cw);
        chk("csr_addr", csr_addr, hd.ca);
        chk("csr_wdata", csr_wdata, hd.res);
        chk("fwd_hit", fwd_hit, hit);
        chk("fwd_data", fwd_data, fd);
        chk("halt", halt, halt_m);
        chk("count", count, q.size());
        chk("retire_cnt", retire_cnt, rc_m);
    endtask

    task automatic drive(input stim_t s);
        cur = s;
        in_valid = s.v; in_rd = s.rd; in_result = s.res; in_reg_write = s.rw;
        in_csr_write = s.cw; in_csr_addr = s.ca; in_ebreak = s.eb;
        wb_ready = s.wr; fwd_rs = s.fr; flush = s.fl;
    endtask

    task automatic apply(input stim_t s);
        @(negedge clock);
        drive(s);
        #1;
        check_all();
    endtask

    task automatic tick();
        ent_t e;
        @(posedge clock);
        if (cur.fl) q.delete();
        else begin
            if (m_pop) begin
                if (q[0].eb) halt_m = 1;
                void'(q.pop_front());
                rc_m++;
            end
            if (m_push) begin
                e.rd = cur.rd; e.res = cur.res; e.rw = cur.rw;
                e.cw = cur.cw; e.ca = cur.ca; e.eb = cur.eb;
                q.push_back(e);
            end
        end
    endtask

    task automatic step(input stim_t s);
        apply(s);
        tick();
    endtask

    task automatic do_reset();
        @(negedge clock);
        drive(mk(1, 3, 'h33, 1, 1, 'h1, 0, 1, 3, 0));
        #2 reset_n = 0;
        #1;
        q.delete(); halt_m = 0; rc_m = 0;
        check_all();
        chk("rst_rdy", in_ready, 1);
        chk("rst_we", rf_we | csr_we, 0);
        chk("rst_hit", fwd_hit, 0);
        chk("rst_cnt", count, 0);
        @(posedge clock);
        #2 reset_n = 1;
    endtask

    initial begin
        stim_t idle, s;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[0] = mkv(mk(1, 1, 'h10, 1, 0, 0, 0, 1, 1, 0), 1, 0, 0, 0,    0, 0, 0,    0);
        tbl[1] = mkv(mk(1, 2, 'h11, 1, 0, 0, 0, 1, 1, 0), 1, 1, 1, 'h10, 1, 1, 'h10, 0);
        tbl[2] = mkv(mk(1, 3, 'h12, 1, 0, 0, 0, 1, 2, 0), 1, 1, 2, 'h11, 1, 1, 'h11, 1);
        tbl[3] = mkv(mk(1, 4, 'h13, 1, 0, 0, 0, 1, 4, 0), 1, 1, 3, 'h12, 1, 0, 0,    2);
        tbl[4] = mkv(mk(0, 0, 0,    0, 0, 0, 0, 1, 4, 0), 1, 1, 4, 'h13, 1, 1, 'h13, 3);
        tbl[5] = mkv(mk(0, 0, 0,    0, 0, 0, 0, 1, 4, 0), 1, 0, 0, 0,    0, 0, 0,    4);

        do_reset();
        foreach (tbl[i]) begin
            apply(tbl[i].s);
            chk("tbl_rdy", in_ready, tbl[i].rdy);
            chk("tbl_we", rf_we, tbl[i].we);
            chk("tbl_rd", rf_rd, tbl[i].rd);
            chk("tbl_wd", rf_wdata, tbl[i].wd);
            chk("tbl_cnt", count, tbl[i].cnt);
            chk("tbl_hit", fwd_hit, tbl[i].hit);
            chk("tbl_fd", fwd_data, tbl[i].fd);
            chk("tbl_rc", retire_cnt, tbl[i].rc);
            tick();
        end

        for (int i = 0; i < 4; i++) step(mk(1, i + 1, 'h20 + i, 1, 0, 0, 0, 0, 0, 0));
        apply(mk(1, 9, 'h99, 1, 0, 0, 0, 0, 0, 0));
        chk("full_rdy", in_ready, 0);
        chk("full_cnt", count, 4);
        tick();
        apply(mk(1, 9, 'h99, 1, 0, 0, 0, 1, 0, 0));
        chk("fullpop_rdy", in_ready, 0);
        chk("fullpop_rd", rf_rd, 1);
        tick();
        apply(idle);
        chk("rdy_back", in_ready, 1);
        chk("next_rd", rf_rd, 2);
        tick();
        repeat (3) step(idle);

        step(mk(1, 5, 'hA, 1, 0, 0, 0, 0, 0, 0));
        step(mk(1, 5, 'hB, 1, 0, 0, 0, 0, 0, 0));
        step(mk(1, 0, 'h55, 1, 0, 0, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0));
        chk("fwd_young_hit", fwd_hit, 1);
        chk("fwd_young_data", fwd_data, 'hB);
        tick();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("fwd_x0", fwd_hit, 0);
        tick();
        step(idle);
        step(idle);
        apply(idle);
        chk("rd0_we", rf_we, 0);
        chk("rd0_wd", rf_wdata, 'h55);
        tick();

        for (int i = 0; i < 3; i++) step(mk(1, i + 1, 'h40 + i, 1, 0, 0, 0, 0, 0, 0));
        apply(mk(1, 6, 'h66, 1, 0, 0, 0, 1, 6, 1));
        chk("flush_we", rf_we, 0);
        chk("flush_rdy", in_ready, 0);
        tick();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 0));
        chk("flush_cnt", count, 0);
        chk("flush_rc", retire_cnt, 11);
        chk("flush_nohit", fwd_hit, 0);
        tick();

        step(mk(1, 0, 'h8000_0000, 0, 1, 'h305, 0, 0, 0, 0));
        step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        step(mk(1, 7, 'h77, 1, 0, 0, 0, 0, 0, 0));
        apply(idle);
        chk("csr_we_dir", csr_we, 1);
        chk("csr_addr_dir", csr_addr, 'h305);
        chk("csr_wdata_dir", csr_wdata, 'h8000_0000);
        tick();
        apply(idle);
        chk("halt_pre", halt, 0);
        tick();
        apply(mk(1, 8, 'h88, 1, 0, 0, 0, 1, 7, 0));
        chk("halt_set", halt, 1);
        chk("halt_rdy", in_ready, 0);
        chk("halt_we", rf_we, 0);
        chk("halt_cnt", count, 1);
        chk("halt_rc", retire_cnt, 13);
        chk("halt_fwd", fwd_hit, 1);
        tick();
        repeat (3) step(idle);
        do_reset();

        for (int n = 0; n < 600; n++) begin
            if (halt_m && $urandom_range(0, 3) == 0) do_reset();
            s = mk($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom,
                   $urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4095),
                   $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6,
                   $urandom_range(0, 7), $urandom_range(0, 15) == 0);
            step(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
